// File: rtl/seg7_channel_display.sv
// Four-digit multiplexed 7-segment voltage display for four BCD channels,
// with manual/automatic channel rotation and a channel-ID banner after each change.
module seg7_channel_display #(
    parameter int REFRESH_DIV = 100000,
    parameter int DWELL_TICKS = 2000,
    parameter int ID_TICKS    = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] channel0,
    input  logic [15:0] channel1,
    input  logic [15:0] channel2,
    input  logic [15:0] channel3,
    input  logic        next_ch,
    input  logic        auto_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  ch_idx
);
    // state    | meaning
    // SHOW_VAL | scanning the snapshot value, dwell counter active when auto_en
    // SHOW_ID  | scanning "C  n" banner for ID_TICKS ticks after a channel change
    typedef enum logic {SHOW_VAL = 1'b0, SHOW_ID = 1'b1} state_t;

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
    localparam int IW = (ID_TICKS > 1) ? $clog2(ID_TICKS) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [DW-1:0] DWELL_LAST   = DW'(DWELL_TICKS - 1);
    localparam logic [IW-1:0] ID_LAST      = IW'(ID_TICKS - 1);

    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    state_t        state;
    logic [RW-1:0] refresh_cnt;
    logic [1:0]    dig;
    logic [DW-1:0] dwell_cnt;
    logic [IW-1:0] id_cnt;
    logic [15:0]   snap;

    logic          tick;
    logic          dwell_exp;
    logic          change;
    logic [1:0]    next_idx;
    logic [15:0]   cur_word;
    logic [15:0]   next_word;
    logic [3:0]    val_nib;
    logic [6:0]    disp_seg;
    logic          disp_dp;

    function automatic logic [6:0] encode(input logic [3:0] n);
        case (n)
            4'd0:    encode = 7'b1000000;
            4'd1:    encode = 7'b1111001;
            4'd2:    encode = 7'b0100100;
            4'd3:    encode = 7'b0110000;
            4'd4:    encode = 7'b0011001;
            4'd5:    encode = 7'b0010010;
            4'd6:    encode = 7'b0000010;
            4'd7:    encode = 7'b1111000;
            4'd8:    encode = 7'b0000000;
            4'd9:    encode = 7'b0010000;
            default: encode = 7'b0111111;
        endcase
    endfunction

    function automatic logic [15:0] pick(input logic [1:0] i, input logic [15:0] c0,
                                         input logic [15:0] c1, input logic [15:0] c2,
                                         input logic [15:0] c3);
        case (i)
            2'd0:    pick = c0;
            2'd1:    pick = c1;
            2'd2:    pick = c2;
            default: pick = c3;
        endcase
    endfunction

    assign tick      = (refresh_cnt == REFRESH_LAST);
    assign dwell_exp = tick && (state == SHOW_VAL) && auto_en && (dwell_cnt == DWELL_LAST);
    // A manual request landing on the expiry cycle merges into the same single step.
    assign change    = next_ch || dwell_exp;
    assign next_idx  = ch_idx + 2'd1;
    assign cur_word  = pick(ch_idx, channel0, channel1, channel2, channel3);
    assign next_word = pick(next_idx, channel0, channel1, channel2, channel3);
    assign val_nib   = snap[{dig, 2'b00} +: 4];

    always_comb begin
        disp_seg = encode(val_nib);
        disp_dp  = (dig != 2'd3);
        if (state == SHOW_ID) begin
            disp_dp = 1'b1;
            case (dig)
                2'd3:    disp_seg = SEG_C;
                2'd0:    disp_seg = encode({2'b00, ch_idx});
                default: disp_seg = SEG_BLANK;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            refresh_cnt <= '0;
            dig         <= 2'd0;
        end else if (tick) begin
            refresh_cnt <= '0;
            dig         <= dig + 2'd1;
        end else begin
            refresh_cnt <= refresh_cnt + RW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= SHOW_VAL;
            ch_idx    <= 2'd0;
            dwell_cnt <= '0;
            id_cnt    <= '0;
            snap      <= 16'h0000;
            an        <= 4'b1111;
            seg       <= SEG_BLANK;
            dp        <= 1'b1;
        end else begin
            an  <= ~(4'b0001 << dig);
            seg <= disp_seg;
            dp  <= disp_dp;
            if (change) begin
                ch_idx    <= next_idx;
                state     <= SHOW_ID;
                id_cnt    <= '0;
                dwell_cnt <= '0;
                snap      <= next_word;
            end else begin
                // Frame-boundary snapshot keeps a frame from mixing old and new digits.
                if (tick && (dig == 2'd3))
                    snap <= cur_word;
                case (state)
                    SHOW_ID: begin
                        dwell_cnt <= '0;
                        if (tick) begin
                            if (id_cnt == ID_LAST) begin
                                state  <= SHOW_VAL;
                                id_cnt <= '0;
                            end else begin
                                id_cnt <= id_cnt + IW'(1);
                            end
                        end
                    end
                    default: begin
                        if (!auto_en)
                            dwell_cnt <= '0;
                        else if (tick)
                            dwell_cnt <= dwell_cnt + DW'(1);
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_seg7_channel_display.sv
// Directed bench for seg7_channel_display with small refresh/dwell/ID periods.
module tb_seg7_channel_display;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] channel0, channel1, channel2, channel3;
    logic        next_ch, auto_en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  ch_idx;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [1:0] exp_ch;
    int t0, t1, t2;

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                           S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                           SD = 7'b0111111, SC = 7'b1000110, SB = 7'b1111111;

    seg7_channel_display #(.REFRESH_DIV(4), .DWELL_TICKS(8), .ID_TICKS(4)) dut (
        .clk(clk), .rst(rst),
        .channel0(channel0), .channel1(channel1), .channel2(channel2), .channel3(channel3),
        .next_ch(next_ch), .auto_en(auto_en),
        .an(an), .seg(seg), .dp(dp), .ch_idx(ch_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_an(input logic [3:0] p, input string tag);
        int n = 0;
        while (an !== p && n < 40) begin @(negedge clk); n++; end
        if (an !== p) begin
            total++; bad++;
            $error("FAIL %s timeout an observed=%b expected=%b", tag, an, p);
        end
    endtask

    task automatic check_digit(input logic [3:0] p, input logic [6:0] s, input logic d,
                               input string tag);
        wait_an(p, tag);
        chk({tag, "_seg"}, 32'(seg), 32'(s));
        chk({tag, "_dp"}, 32'(dp), 32'(d));
    endtask

    task automatic frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                         input logic [6:0] s3, input logic d3, input string tag);
        check_digit(4'b1110, s0, 1'b1, {tag, "_d0"});
        check_digit(4'b1101, s1, 1'b1, {tag, "_d1"});
        check_digit(4'b1011, s2, 1'b1, {tag, "_d2"});
        check_digit(4'b0111, s3, d3, {tag, "_d3"});
    endtask

    task automatic pulse_next(input string tag);
        @(negedge clk); next_ch = 1'b1;
        @(negedge clk); next_ch = 1'b0;
        exp_ch = exp_ch + 2'd1;
        chk(tag, 32'(ch_idx), 32'(exp_ch));
    endtask

    // Pulse right after digit 0 appears so the whole banner frame follows in order.
    task automatic pulse_aligned(input string tag);
        int n = 0;
        while (an === 4'b1110 && n < 40) begin @(negedge clk); n++; end
        wait_an(4'b1110, {tag, "_align"});
        next_ch = 1'b1;
        @(negedge clk); next_ch = 1'b0;
        exp_ch = exp_ch + 2'd1;
        chk(tag, 32'(ch_idx), 32'(exp_ch));
        @(negedge clk);
    endtask

    task automatic wait_change(output int at_cyc, input string tag);
        int n = 0;
        while (ch_idx === exp_ch && n < 200) begin @(negedge clk); n++; end
        exp_ch = exp_ch + 2'd1;
        chk(tag, 32'(ch_idx), 32'(exp_ch));
        at_cyc = cyc;
    endtask

    initial begin
        rst = 1'b0; next_ch = 1'b0; auto_en = 1'b0; exp_ch = 2'd0;
        channel0 = 16'h1234; channel1 = 16'h5678; channel2 = 16'hA0F5; channel3 = 16'h9999;
        repeat (3) @(negedge clk);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'(SB));
        chk("rst_dp", 32'(dp), 32'h1);
        chk("rst_ch", 32'(ch_idx), 32'h0);

        // first frame timing: digit 0 on first edge, held 4 cycles, snapshot still 0
        rst = 1'b1;
        @(negedge clk);
        chk("f1_an0", 32'(an), 32'hE);
        chk("f1_seg0", 32'(seg), 32'(S0));
        chk("f1_dp0", 32'(dp), 32'h1);
        repeat (3) @(negedge clk);
        chk("f1_an0_hold", 32'(an), 32'hE);
        @(negedge clk);
        chk("f1_an1", 32'(an), 32'hD);
        repeat (16) @(negedge clk);
        frame(S4, S3, S2, S1, 1'b0, "ch0_val");

        pulse_aligned("next_to1");
        frame(S1, SB, SB, SC, 1'b1, "ch1_id");
        frame(S8, S7, S6, S5, 1'b0, "ch1_val");

        pulse_next("next_to2");
        repeat (20) @(negedge clk);
        frame(S5, SD, S0, SD, 1'b0, "ch2_val");

        pulse_next("next_to3");
        pulse_aligned("wrap_to0");
        frame(S0, SB, SB, SC, 1'b1, "ch0_id");

        auto_en = 1'b1;
        wait_change(t0, "auto_a");
        wait_change(t1, "auto_b");
        chk("auto_period", 32'(t1 - t0), 32'd48);
        repeat (47) @(negedge clk);
        next_ch = 1'b1;
        @(negedge clk); next_ch = 1'b0;
        exp_ch = exp_ch + 2'd1;
        chk("coincide_single", 32'(ch_idx), 32'(exp_ch));
        t1 = cyc;
        wait_change(t2, "auto_c");
        chk("auto_period2", 32'(t2 - t1), 32'd48);
        auto_en = 1'b0;

        while (exp_ch != 2'd2) pulse_next("to_two");
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_an", 32'(an), 32'hF);
        chk("async_seg", 32'(seg), 32'(SB));
        chk("async_dp", 32'(dp), 32'h1);
        chk("async_ch", 32'(ch_idx), 32'h0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("rel_an", 32'(an), 32'hE);
        chk("rel_seg", 32'(seg), 32'(S0));
        chk("rel_ch", 32'(ch_idx), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seg7_channel_display.md
SEG7_CHANNEL_DISPLAY -- requirements
Module: seg7_channel_display

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clk cycles per digit-scan tick (1 kHz/digit at 100 MHz).
REQ-002 SHALL have parameter DWELL_TICKS, default 2000, scan ticks per channel in auto-rotate mode.
REQ-003 SHALL have parameter ID_TICKS, default 500, scan ticks the channel-ID banner is shown after a channel change.
REQ-004 SHALL have port clk, input, 1, the single system clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports channel0..channel3, input, 16 each, four BCD digits per channel (bits 15:12 most significant, value X.XXX V).
REQ-007 SHALL have port next_ch, input, 1, single-cycle pulse requesting the next channel.
REQ-008 SHALL have port auto_en, input, 1, level enabling automatic channel rotation.
REQ-009 SHALL have port an, output, 4, digit anodes, active-low, an[0] rightmost.
REQ-010 SHALL have port seg, output, 7, cathodes active-low, seg[0]=a ... seg[6]=g.
REQ-011 SHALL have port dp, output, 1, decimal point, active-low.
REQ-012 SHALL have port ch_idx, output, 2, currently selected channel.

Function
REQ-013 SHALL count 0..REFRESH_DIV-1 and assert an internal tick for one cycle when the count is REFRESH_DIV-1, then wrap to 0.
REQ-014 SHALL advance the digit index 0->1->2->3->0 on each tick.
REQ-015 SHALL drive an with a single 0 at the digit-index position; an, seg, dp registered with one-cycle latency from the index.
REQ-016 SHALL latch the selected channel word into a snapshot register on the tick where the digit index wraps 3->0, and on every channel change; displayed digits come only from the snapshot (no tearing within a frame).
REQ-017 SHALL implement FSM states SHOW_ID and SHOW_VAL.
REQ-018 In SHOW_VAL: digit n SHALL show snapshot nibble n; dp=0 only on digit 3, else 1.
REQ-019 In SHOW_ID: digit 3 SHALL show "C" (7'b1000110), digits 2 and 1 blank (7'b1111111), digit 0 the ch_idx numeral; dp=1.
REQ-020 Encoding SHALL be standard: 0=7'b1000000, 1=7'b1111001, 2=7'b0100100, 3=7'b0110000 ... 9=7'b0010000; nibbles 10-15 SHALL display dash 7'b0111111.
REQ-021 A channel change (next_ch pulse, or dwell expiry) SHALL increment ch_idx mod 4 (3->0), enter SHOW_ID, clear ID and dwell counters.
REQ-022 SHOW_ID SHALL transition to SHOW_VAL after ID_TICKS ticks.
REQ-023 Dwell counter SHALL count ticks only in SHOW_VAL with auto_en=1; expiry at DWELL_TICKS; cleared when auto_en=0.
REQ-024 next_ch coinciding with dwell expiry SHALL produce exactly one increment.
REQ-025 next_ch during SHOW_ID SHALL advance ch_idx and restart the ID period.
REQ-026 Refresh counter and digit index SHALL run free, unaffected by channel changes.

Reset
REQ-027 While rst=0: an=4'b1111, seg=7'b1111111, dp=1, ch_idx=0, state SHOW_VAL, all counters, digit index and snapshot 0.
REQ-028 Reset assertion mid-frame or mid-ID SHALL take effect immediately (asynchronous); first output update on the first clk edge after release shows digit 0.

Verification (REFRESH_DIV=4, DWELL_TICKS=8, ID_TICKS=4)
REQ-029 Release reset, channel0=16'h1234, auto_en=0 -> an cycles 1110,1101,1011,0111 every 4 cycles; seg shows 4,3,2,1 after first frame; dp=0 only with an=0111.
REQ-030 Pulse next_ch -> ch_idx=1, banner C,blank,blank,1 for 4 ticks, then channel1 value.
REQ-031 ch_idx=3, pulse next_ch -> ch_idx=0, banner digit 0 = 7'b1000000.
REQ-032 auto_en=1 -> ch_idx advances every 12 ticks (4 ID + 8 dwell); next_ch on expiry cycle -> single increment.
REQ-033 channel2=16'hA0F5 selected -> digits show dash,0,dash,5.
REQ-034 Assert rst mid-ID with ch_idx=2 -> outputs blank and ch_idx=0 before next clk edge.
